// File: rtl/la_capture_ctrl.sv
// Capture/readout sequencer for the logic-analyzer circular sample buffer.
// Arms, captures with qualified pre-trigger history, freezes, then streams the buffer oldest-first.
module la_capture_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trigger,
  input  logic [ADDR_WIDTH-1:0] post_count,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  read_enable,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  triggered,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = '1;
  localparam int                    LAT_WIDTH  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LAT_WIDTH-1:0]  LAT_LAST   = LAT_WIDTH'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    POSTTRIG,
    RD_ISSUE,
    RD_WAIT,
    PRESENT,
    DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   waddr_reg, waddr_next;
  logic [ADDR_WIDTH-1:0]   rd_addr_reg, rd_addr_next;
  logic [ADDR_WIDTH-1:0]   trig_addr_reg, trig_addr_next;
  logic [ADDR_WIDTH-1:0]   post_len_reg, post_len_next;
  logic [ADDR_WIDTH-1:0]   post_cnt_reg, post_cnt_next;
  logic [ADDR_WIDTH-1:0]   fill_cnt_reg, fill_cnt_next;
  logic [ADDR_WIDTH-1:0]   word_cnt_reg, word_cnt_next;
  logic [LAT_WIDTH-1:0]    lat_cnt_reg, lat_cnt_next;
  logic [DATA_WIDTH-1:0]   out_data_reg, out_data_next;
  logic                    triggered_reg, triggered_next;
  logic                    capture;
  logic                    qualified;

  assign capture = (state_reg == PRETRIG) || (state_reg == POSTTRIG);
  // Enough history is stored that the buffer is fully valid once post_len more samples land.
  assign qualified = trigger && (fill_cnt_reg >= (LAST_INDEX - post_len_reg));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      waddr_reg     <= '0;
      rd_addr_reg   <= '0;
      trig_addr_reg <= '0;
      post_len_reg  <= '0;
      post_cnt_reg  <= '0;
      fill_cnt_reg  <= '0;
      word_cnt_reg  <= '0;
      lat_cnt_reg   <= '0;
      out_data_reg  <= '0;
      triggered_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      waddr_reg     <= waddr_next;
      rd_addr_reg   <= rd_addr_next;
      trig_addr_reg <= trig_addr_next;
      post_len_reg  <= post_len_next;
      post_cnt_reg  <= post_cnt_next;
      fill_cnt_reg  <= fill_cnt_next;
      word_cnt_reg  <= word_cnt_next;
      lat_cnt_reg   <= lat_cnt_next;
      out_data_reg  <= out_data_next;
      triggered_reg <= triggered_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    waddr_next     = waddr_reg;
    rd_addr_next   = rd_addr_reg;
    trig_addr_next = trig_addr_reg;
    post_len_next  = post_len_reg;
    post_cnt_next  = post_cnt_reg;
    fill_cnt_next  = fill_cnt_reg;
    word_cnt_next  = word_cnt_reg;
    lat_cnt_next   = lat_cnt_reg;
    out_data_next  = out_data_reg;
    triggered_next = triggered_reg;
    write_enable   = capture;
    read_enable    = (state_reg == RD_ISSUE);

    // The pointer follows every write strobe, including one issued in an aborted cycle.
    if (capture) begin
      waddr_next = waddr_reg + ADDR_WIDTH'(1);
      if (fill_cnt_reg != LAST_INDEX) begin
        fill_cnt_next = fill_cnt_reg + ADDR_WIDTH'(1);
      end
    end

    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (arm) begin
            post_len_next  = post_count;
            fill_cnt_next  = '0;
            triggered_next = 1'b0;
            state_next     = PRETRIG;
          end
        end
        PRETRIG: begin
          if (qualified) begin
            trig_addr_next = waddr_reg;
            triggered_next = 1'b1;
            post_cnt_next  = post_len_reg;
            if (post_len_reg == '0) begin
              state_next    = RD_ISSUE;
              rd_addr_next  = waddr_reg + ADDR_WIDTH'(1);
              word_cnt_next = '0;
            end else begin
              state_next = POSTTRIG;
            end
          end
        end
        POSTTRIG: begin
          post_cnt_next = post_cnt_reg - ADDR_WIDTH'(1);
          if (post_cnt_reg == ADDR_WIDTH'(1)) begin
            state_next    = RD_ISSUE;
            rd_addr_next  = waddr_reg + ADDR_WIDTH'(1);
            word_cnt_next = '0;
          end
        end
        RD_ISSUE: begin
          lat_cnt_next = '0;
          state_next   = RD_WAIT;
        end
        RD_WAIT: begin
          if (lat_cnt_reg == LAT_LAST) begin
            out_data_next = rd_data;
            state_next    = PRESENT;
          end else begin
            lat_cnt_next = lat_cnt_reg + LAT_WIDTH'(1);
          end
        end
        PRESENT: begin
          if (out_ready) begin
            rd_addr_next  = rd_addr_reg + ADDR_WIDTH'(1);
            word_cnt_next = word_cnt_reg + ADDR_WIDTH'(1);
            state_next    = (word_cnt_reg == LAST_INDEX) ? DONE : RD_ISSUE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign waddr     = waddr_reg;
  assign rd_addr   = rd_addr_reg;
  assign trig_addr = trig_addr_reg;
  assign out_data  = out_data_reg;
  assign out_valid = (state_reg == PRESENT);
  assign triggered = triggered_reg;
  assign busy      = (state_reg != IDLE) && (state_reg != DONE);
  assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Bench for la_capture_ctrl: buffer emulation plus a run-level reference model
// (trigger index, write count and expected oldest-first word list derived from the capture rules).
`timescale 1ns/1ps
module tb_la_capture_ctrl;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int MEM = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          trigger = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] post_count = '0;
  logic          write_enable, read_enable, out_valid, triggered, busy, done;
  logic [AW-1:0] waddr, rd_addr, trig_addr;
  logic [DW-1:0] rd_data, out_data;

  logic [DW-1:0] mem [0:MEM-1];
  logic [DW-1:0] rd_s1 = '0;
  logic [DW-1:0] rd_s2 = '0;
  logic [DW-1:0] sample_cnt = '0;
  logic          trig_pat [0:63];
  int            n_checks = 0;
  int            n_fail = 0;
  int            m_waddr = 0;

  la_capture_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trigger(trigger),
    .post_count(post_count), .write_enable(write_enable), .waddr(waddr),
    .read_enable(read_enable), .rd_addr(rd_addr), .rd_data(rd_data),
    .trig_addr(trig_addr), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .triggered(triggered), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Sample source and two-stage synchronous-read buffer.
  always @(posedge clk) begin
    sample_cnt <= sample_cnt + 8'd1;
    if (write_enable === 1'b1) mem[waddr] <= sample_cnt;
    if (read_enable === 1'b1) rd_s1 <= mem[rd_addr];
    rd_s2 <= rd_s1;
  end
  assign rd_data = rd_s2;

  task automatic fill_random_pattern();
    for (int i = 0; i < 64; i++) trig_pat[i] = ($urandom_range(0, 3) == 0);
    trig_pat[40] = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      arm = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
      trigger = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      post_count = AW'($urandom);
      @(negedge clk);
      n_checks++;
      if ({write_enable, waddr, read_enable, rd_addr, trig_addr, out_data, out_valid,
           triggered, busy, done} !== 26'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %h, want 0", c,
                 {write_enable, waddr, read_enable, rd_addr, trig_addr, out_data, out_valid,
                  triggered, busy, done});
      end
    end
    reset = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0; out_ready = 1'b0;
    m_waddr = 0;
    $display("reset: 3 cycles checked");
  endtask

  // One full run: arm, capture against trig_pat, then read out and compare to the model.
  task automatic run_capture(input int post, input int stall_word, input int abort_word,
                             input string tag);
    int k, n, w, guard, stall, start, fin;
    logic [DW-1:0] exp_q[$];
    k = -1;
    for (int j = 0; j < 64; j++) if (k < 0 && trig_pat[j] && j >= MEM - 1 - post) k = j;
    if (k < 0) begin
      n_fail++;
      $display("FAIL %s pattern: no qualifying trigger in stimulus", tag);
      return;
    end
    n = k + 1 + post;
    start = m_waddr;
    fin = (start + n) % MEM;

    arm = 1'b1; post_count = AW'(post); trigger = 1'($urandom_range(0, 1));
    @(negedge clk);
    arm = 1'b0; post_count = AW'($urandom);
    for (int j = 0; j < n; j++) begin
      n_checks++;
      if (write_enable !== 1'b1 || busy !== 1'b1 || waddr !== AW'((start + j) % MEM)) begin
        n_fail++;
        $display("FAIL %s capture_write %0d: got we=%b busy=%b waddr=%0d, want we=1 busy=1 waddr=%0d",
                 tag, j, write_enable, busy, waddr, (start + j) % MEM);
      end
      exp_q.push_back(sample_cnt);
      trigger = trig_pat[j];
      @(negedge clk);
    end
    m_waddr = fin;
    trigger = 1'($urandom_range(0, 1));
    n_checks++;
    if (write_enable !== 1'b0 || waddr !== AW'(fin) || triggered !== 1'b1 ||
        trig_addr !== AW'((start + k) % MEM)) begin
      n_fail++;
      $display("FAIL %s freeze: got we=%b waddr=%0d trg=%b trig_addr=%0d, want we=0 waddr=%0d trg=1 trig_addr=%0d",
               tag, write_enable, waddr, triggered, trig_addr, fin, (start + k) % MEM);
    end

    w = 0; guard = 0; stall = 0;
    while (w < MEM && guard < 500) begin
      guard++;
      if (read_enable === 1'b1) begin
        n_checks++;
        if (rd_addr !== AW'((fin + w) % MEM)) begin
          n_fail++;
          $display("FAIL %s rd_addr word %0d: got %0d, want %0d", tag, w, rd_addr, (fin + w) % MEM);
        end
      end
      if (out_valid === 1'b1) begin
        n_checks++;
        if (out_data !== exp_q[n - MEM + w] || read_enable !== 1'b0) begin
          n_fail++;
          $display("FAIL %s word %0d: got data=%h re=%b, want data=%h re=0",
                   tag, w, out_data, read_enable, exp_q[n - MEM + w]);
        end
        if (w == abort_word) begin
          abort = 1'b1; out_ready = 1'b0;
          @(negedge clk);
          abort = 1'b0;
          n_checks++;
          if (out_valid !== 1'b0 || busy !== 1'b0 || read_enable !== 1'b0 ||
              write_enable !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s abort: got valid=%b busy=%b re=%b we=%b done=%b, want all 0",
                     tag, out_valid, busy, read_enable, write_enable, done);
          end
          $display("run %s: post=%0d k=%0d writes=%0d aborted at word %0d", tag, post, k, n, w);
          return;
        end
        if (w == stall_word && stall < 5) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
        if (out_ready) w++;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_checks++;
    if (w != MEM) begin
      n_fail++;
      $display("FAIL %s readout_timeout: got %0d words, want %0d", tag, w, MEM);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || triggered !== 1'b1 ||
        trig_addr !== AW'((start + k) % MEM)) begin
      n_fail++;
      $display("FAIL %s done_state: got done=%b busy=%b valid=%b trg=%b trig_addr=%0d, want 1 0 0 1 %0d",
               tag, done, busy, out_valid, triggered, trig_addr, (start + k) % MEM);
    end
    $display("run %s: post=%0d k=%0d writes=%0d trig_addr=%0d words=%0d",
             tag, post, k, n, (start + k) % MEM, w);
  endtask

  task automatic test_trigger_hold();
    for (int i = 0; i < 64; i++) trig_pat[i] = (i >= 1);
    run_capture(4, -1, -1, "trigger_hold");
  endtask

  task automatic test_post_zero_wrap();
    for (int i = 0; i < 64; i++) trig_pat[i] = (i == 20);
    run_capture(0, -1, -1, "post_zero_wrap");
  endtask

  task automatic test_backpressure();
    fill_random_pattern();
    run_capture(int'($urandom_range(0, 15)), 3, -1, "backpressure");
  endtask

  task automatic test_abort_readout();
    fill_random_pattern();
    run_capture(int'($urandom_range(0, 15)), -1, 7, "abort_readout");
    fill_random_pattern();
    run_capture(int'($urandom_range(0, 15)), -1, -1, "recapture");
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 3; r++) begin
      fill_random_pattern();
      run_capture(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), -1, "random");
    end
    fill_random_pattern();
    trig_pat[0] = 1'b1;
    run_capture(15, -1, -1, "post_max");
  endtask

  task automatic test_early_trigger();
    arm = 1'b1; post_count = AW'(2); trigger = 1'b0;
    @(negedge clk);
    arm = 1'b0;
    for (int j = 0; j < 20; j++) begin
      n_checks++;
      if (write_enable !== 1'b1 || triggered !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL early_trigger cycle %0d: got we=%b trg=%b busy=%b done=%b, want 1 0 1 0",
                 j, write_enable, triggered, busy, done);
      end
      trigger = (j == 5);
      @(negedge clk);
    end
    trigger = 1'b0; abort = 1'b1;
    @(negedge clk);
    arm = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || write_enable !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL early_abort: got busy=%b we=%b valid=%b, want 0 0 0", busy, write_enable, out_valid);
    end
    @(negedge clk);
    abort = 1'b0; arm = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_over_arm: got busy=%b we=%b, want 0 0", busy, write_enable);
    end
    $display("early_trigger: pulse below threshold ignored for 20 cycles");
  endtask

  task automatic test_reset_midrun();
    arm = 1'b1; post_count = AW'(7);
    @(negedge clk);
    arm = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_checks++;
    if ({write_enable, waddr, read_enable, rd_addr, trig_addr, out_data, out_valid,
         triggered, busy, done} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_midrun: got %h, want 0",
               {write_enable, waddr, read_enable, rd_addr, trig_addr, out_data, out_valid,
                triggered, busy, done});
    end
    m_waddr = 0;
    $display("reset_midrun: outputs cleared");
    fill_random_pattern();
    run_capture(int'($urandom_range(0, 15)), -1, -1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_trigger_hold();
    test_post_zero_wrap();
    test_backpressure();
    test_abort_readout();
    test_random_runs();
    test_early_trigger();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
